// File: rtl/pc_fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and the PC/MAR/IR datapath plus
// the execute controller. The sequencer side uses the master modport.
interface pc_fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  // Inputs to the sequencer
  logic             mem_ready;
  logic             exec_done;
  logic             branch_taken;
  logic             halt_req;
  logic             run;
  // Datapath strobes and status
  logic             pc_bus;
  logic             pc_inc;
  logic             pc_load;
  logic             pc_reset;
  logic             mar_load;
  logic             mem_rd;
  logic             ir_load;
  logic             exec_start;
  logic             halted;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  mem_ready, exec_done, branch_taken, halt_req, run,
    output pc_bus, pc_inc, pc_load, pc_reset, mar_load, mem_rd, ir_load,
           exec_start, halted, bus_err, state, instr_count
  );

  modport slave (
    output mem_ready, exec_done, branch_taken, halt_req, run,
    input  pc_bus, pc_inc, pc_load, pc_reset, mar_load, mem_rd, ir_load,
           exec_start, halted, bus_err, state, instr_count
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch sequencer: walks ADDR -> READ -> IR -> EXEC for every
// instruction, guards the memory read with a timeout, counts retired
// instructions and parks in HALT (resumable) or ERR (reset only).
module pc_fetch_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pc_fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_IR    = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Last S_READ cycle count value before the timeout fires
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       tmo_q;
  logic             exec_entry_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  assign retire = (state_q == S_EXEC) && bus.exec_done;

  // Next-state decision
  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_ADDR;
      S_ADDR:  state_d = S_READ;
      S_READ: begin
        // Ready on the final allowed cycle still wins over the timeout
        if (bus.mem_ready)           state_d = S_IR;
        else if (tmo_q == TMO_LAST)  state_d = S_ERR;
      end
      S_IR:    state_d = S_EXEC;
      S_EXEC:  if (bus.exec_done) state_d = bus.halt_req ? S_HALT : S_ADDR;
      S_HALT:  if (bus.run) state_d = S_ADDR;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RESET;
    endcase
  end

  // State register, read timeout, EXEC entry marker, sticky error, retire count
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RESET;
      tmo_q        <= '0;
      exec_entry_q <= 1'b0;
      bus_err_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= (state_q == S_READ && state_d == S_READ) ? tmo_q + 8'd1 : '0;
      exec_entry_q <= (state_q == S_IR);
      bus_err_q    <= bus_err_q | (state_d == S_ERR);
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Strobe decode from registered state; only pc_load follows inputs
  always_comb begin
    bus.pc_bus     = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.pc_reset   = 1'b0;
    bus.mar_load   = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.exec_start = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      S_RESET: bus.pc_reset = 1'b1;
      S_ADDR: begin
        bus.pc_bus   = 1'b1;
        bus.mar_load = 1'b1;
      end
      S_READ:  bus.mem_rd = 1'b1;
      S_IR: begin
        bus.ir_load = 1'b1;
        bus.pc_inc  = 1'b1;
      end
      S_EXEC: begin
        bus.exec_start = exec_entry_q;
        bus.pc_load    = bus.exec_done & bus.branch_taken;
      end
      S_HALT:  bus.halted = 1'b1;
      S_ERR:   bus.halted = 1'b1;
      default: bus.pc_reset = 1'b1;
    endcase
  end

  assign bus.bus_err     = bus_err_q;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
